apb_master: RTL and testbench

APB requester that converts single-beat commands from a local controller (valid/ready) into APB SETUP/ACCESS transfers on an 8-bit APB bus. It returns the read data and the slave error status as a held response. It drives the same bus signals consumed by the team's APB slave peripherals, and sits between the local controller and the peripheral bus.

---
 rtl/apb_pkg.sv | 35 +++
 rtl/apb_master_wdt.sv | 40 ++++
 rtl/apb_master.sv | 171 +++++++++++++++++
 tb/tb_apb_master.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB requester and the team's APB peripherals.
//   Holds the requester FSM state encoding, the command and response record
//   types at the default bus widths, and the default width and watchdog
//   constants used as parameter defaults by apb_master.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_TIMEOUT = 16;

  // Width of the ACCESS-phase watchdog counter; bounds the legal TIMEOUT.
  localparam int APB_WDT_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_wdt.sv
// ---------------------------------------------------------------------------
// apb_master_wdt
//   ACCESS-phase watchdog for apb_master. Counts ACCESS cycles in which the
//   slave holds pready low and flags the cycle in which the TIMEOUT-th such
//   cycle is being spent, so the requester can abort on that edge.
//
// Ports
//   pclk      in   clock, rising edge
//   prst      in   synchronous active-high reset
//   clear     in   restart the count (asserted in SETUP, i.e. on ACCESS entry)
//   count_en  in   ACCESS cycle with pready low
//   expired   out  abort at the coming edge
// ---------------------------------------------------------------------------
module apb_master_wdt
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic pclk,
  input  logic prst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [APB_WDT_W-1:0] count;

  always_ff @(posedge pclk) begin
    if (prst || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  // The count holds the number of stalled cycles already completed, so the
  // limit is hit while the TIMEOUT-th stalled cycle is in progress.
  assign expired = count_en && (count == APB_WDT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   APB requester: turns single-beat valid/ready commands from the local
//   controller into APB SETUP/ACCESS transfers and returns read data and the
//   slave error status as a response held until rsp_ready.
//
//   Optional feature: define APB_MASTER_TIMEOUT_EN to add an ACCESS-phase
//   watchdog (apb_master_wdt) that aborts a transfer after TIMEOUT stalled
//   cycles and reports rsp_err=1, rsp_timeout=1. Without it ACCESS waits
//   indefinitely and rsp_timeout is tied to 0.
//
// Ports
//   pclk, prst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err/rsp_timeout  held response payload
//   psel/penable/pwrite/paddr/pwdata  APB request outputs
//   prdata/pready/pslverr          APB completion inputs
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be within 1..65535");
  end

  apb_state_e state_q, state_d;
  logic       accept;
  logic       complete;
  logic       abort;
  logic       wdt_expired;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // psel/penable decode straight from the state register, so they drop on
  // the same edge that returns the FSM to IDLE.
  always_comb begin
    state_d   = state_q;
    psel      = 1'b0;
    penable   = 1'b0;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending response blocks new commands, which also guarantees an
        // idle bus cycle between transfers.
        cmd_ready = !prst && !rsp_valid;
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready wins over the watchdog when both land on the same edge.
        if (pready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (wdt_expired) begin
          abort    = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else if (accept) begin
      pwrite    <= cmd_write;
      paddr     <= cmd_addr;
      pwdata    <= cmd_wdata;
    end
  end

  // Read data is only passed through for error-free reads; writes, slave
  // errors and aborts all report zero.
  always_ff @(posedge pclk) begin
    if (prst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (complete) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
      rsp_err   <= pslverr;
    end else if (abort) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  logic timeout_q;

  apb_master_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .pclk     (pclk),
    .prst     (prst),
    .clear    (state_q == SETUP),
    .count_en ((state_q == ACCESS) && !pready),
    .expired  (wdt_expired)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      timeout_q <= 1'b0;
    end else if (complete) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign wdt_expired = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//   Directed self-checking bench for apb_master (ADDR_W=DATA_W=8, TIMEOUT=4).
//   The APB slave side is driven directly by each scenario task. Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_apb_master;

  logic       pclk;
  logic       prst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (4)
  ) dut (
    .pclk        (pclk),
    .prst        (prst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Presents a command for one cycle; it is accepted at the edge that ends
  // the call, leaving the DUT in SETUP.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    prst      = 1'b1;
    cmd_valid = 1'b1;
    repeat (2) tick();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !== 31'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h expected 0", {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready});
    end
    cmd_valid = 1'b0;
    prst      = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    pready    = 1'b1;
    rsp_ready = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h10;
    cmd_wdata = 8'h5A;
    cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_accept_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {1'b1, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_setup: sel=%b en=%b wr=%b addr=%h wdata=%h rv=%b expected 1 0 1 10 5a 0", psel, penable, pwrite, paddr, pwdata, rsp_valid);
    end
    tick();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {1'b1, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_access: sel=%b en=%b wr=%b addr=%h wdata=%h rv=%b expected 1 1 1 10 5a 0", psel, penable, pwrite, paddr, pwdata, rsp_valid);
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL write_response: sel=%b en=%b rv=%b err=%b rdata=%h crdy=%b expected 0 0 1 0 00 0", psel, penable, rsp_valid, rsp_err, rsp_rdata, cmd_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, cmd_ready, paddr, pwdata} !== {1'b0, 1'b1, 8'h10, 8'h5A}) begin
      errors++;
      $display("[TB] FAIL write_consumed: rv=%b crdy=%b addr=%h wdata=%h expected 0 1 10 5a", rsp_valid, cmd_ready, paddr, pwdata);
    end
  endtask

  task automatic test_read_wait();
    rsp_ready = 1'b1;
    issue(1'b0, 8'h10, 8'hEE);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({psel, penable, pwrite, paddr, rsp_valid} !== {1'b1, 1'b1, 1'b0, 8'h10, 1'b0}) begin
        errors++;
        $display("[TB] FAIL read_wait_access[%0d]: sel=%b en=%b wr=%b addr=%h rv=%b expected 1 1 0 10 0", i, psel, penable, pwrite, paddr, rsp_valid);
      end
      if (i == 3) begin
        pready  = 1'b1;
        prdata  = 8'h5A;
        pslverr = 1'b0;
      end else begin
        pready  = 1'b0;
        prdata  = 8'hFF;
        pslverr = 1'b1;
      end
      tick();
    end
    prdata  = 8'h00;
    pslverr = 1'b0;
    checks++;
    if ({psel, penable, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL read_wait_response: sel=%b en=%b rv=%b rdata=%h err=%b to=%b expected 0 0 1 5a 0 0", psel, penable, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    tick();
  endtask

  task automatic test_slave_error();
    rsp_ready = 1'b1;
    pready    = 1'b1;
    issue(1'b0, 8'hC9, 8'h00);
    pslverr = 1'b1;
    prdata  = 8'h77;
    tick();
    checks++;
    if ({penable, paddr} !== {1'b1, 8'hC9}) begin
      errors++;
      $display("[TB] FAIL error_access: en=%b addr=%h expected 1 c9", penable, paddr);
    end
    tick();
    pslverr = 1'b0;
    prdata  = 8'h00;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL error_response: rv=%b err=%b rdata=%h expected 1 1 00", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    pready    = 1'b1;
    prdata    = 8'h3C;
    issue(1'b0, 8'h33, 8'h00);
    // Next command is presented at once and held until it is taken.
    cmd_write = 1'b1;
    cmd_addr  = 8'h34;
    cmd_wdata = 8'hA5;
    cmd_valid = 1'b1;
    tick();
    tick();
    prdata = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cmd_ready, psel, rsp_valid, rsp_rdata, rsp_err} !== {1'b0, 1'b0, 1'b1, 8'h3C, 1'b0}) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: crdy=%b sel=%b rv=%b rdata=%h err=%b expected 0 0 1 3c 0", i, cmd_ready, psel, rsp_valid, rsp_rdata, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, cmd_ready, psel, rsp_rdata} !== {1'b0, 1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("[TB] FAIL backpressure_release: rv=%b crdy=%b sel=%b rdata=%h expected 0 1 0 3c", rsp_valid, cmd_ready, psel, rsp_rdata);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 8'h34, 8'hA5}) begin
      errors++;
      $display("[TB] FAIL backpressure_next_setup: sel=%b en=%b wr=%b addr=%h wdata=%h expected 1 0 1 34 a5", psel, penable, pwrite, paddr, pwdata);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    pready    = 1'b0;
    issue(1'b0, 8'h42, 8'h00);
    tick();
    prst = 1'b1;
    tick();
    checks++;
    if ({psel, penable, rsp_valid, paddr} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_mid_access: sel=%b en=%b rv=%b addr=%h expected 0 0 0 00", psel, penable, rsp_valid, paddr);
    end
    prst   = 1'b0;
    pready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({psel, rsp_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_mid_dropped: sel=%b rv=%b expected 0 0", psel, rsp_valid);
    end
    // A pending response is also discarded by reset.
    rsp_ready = 1'b0;
    issue(1'b1, 8'h01, 8'h02);
    repeat (2) tick();
    prst = 1'b1;
    tick();
    prst = 1'b0;
    checks++;
    if ({rsp_valid, psel} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_clears_rsp: rv=%b sel=%b expected 0 0", rsp_valid, psel);
    end
    rsp_ready = 1'b1;
    tick();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = 8'hAB;
    issue(1'b0, 8'h55, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        errors++;
        $display("[TB] FAIL timeout_access[%0d]: sel=%b en=%b rv=%b expected 1 1 0", i, psel, penable, rsp_valid);
      end
      tick();
    end
    checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL timeout_response: sel=%b en=%b rv=%b err=%b to=%b rdata=%h expected 0 0 1 1 1 00", psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    rsp_ready = 1'b1;
    pready    = 1'b1;
    tick();
    issue(1'b0, 8'h56, 8'h00);
    repeat (2) tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 8'hAB}) begin
      errors++;
      $display("[TB] FAIL timeout_cleared: rv=%b err=%b to=%b rdata=%h expected 1 0 0 ab", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    rsp_ready = 1'b1;
    pready    = 1'b0;
    prdata    = 8'hC3;
    issue(1'b0, 8'h60, 8'h00);
    repeat (21) tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL no_timeout_wait: sel=%b en=%b rv=%b expected 1 1 0", psel, penable, rsp_valid);
    end
    pready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 8'hC3}) begin
      errors++;
      $display("[TB] FAIL no_timeout_response: rv=%b err=%b to=%b rdata=%h expected 1 0 0 c3", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    tick();
  endtask
`endif

  initial begin
    prst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    prdata    = 8'h00;
    pready    = 1'b0;
    pslverr   = 1'b0;

    test_reset();
    test_write();
    test_read_wait();
    test_slave_error();
    test_back_pressure();
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
